// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: encodings shared by the jump control and the PC sequencer.
//   jump_op_e  : JumpOP next-PC select codes (PC+4 / branch / JR / jump).
//   pc_state_e : RUN / HOLD state codes of the PC sequencer FSM.
//   PC_STEP    : sequential instruction stride in bytes.
//   branch_offset() : word offset -> sign-extended byte offset.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    PCOUT_PLUS4 = 2'd0,
    BRANCH      = 2'd1,
    JR          = 2'd2,
    JUMP        = 2'd3
  } jump_op_e;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Branch immediates count words; shift left two and sign-extend to 32 bits.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: bundle between the jump/decode side and the PC sequencer.
//   JumpOP   [1:0]  next-PC select (see jump_op_e)
//   Stall           hold PC this cycle
//   Imm      [15:0] branch offset in words
//   RsData   [31:0] JR target
//   JTarget  [25:0] J-format target field
//   PCout    [31:0] current PC (registered)
//   PC_plus4 [31:0] PCout + 4 (combinational)
//   Flush           one-cycle pulse when a redirect commits
//   Misalign        one-cycle pulse when a committed JR target was unaligned
// master: the side issuing control; slave: the PC sequencer.
interface pc_ctrl_if;
  logic [1:0]  JumpOP;
  logic        Stall;
  logic [15:0] Imm;
  logic [31:0] RsData;
  logic [25:0] JTarget;
  logic [31:0] PCout;
  logic [31:0] PC_plus4;
  logic        Flush;
  logic        Misalign;

  modport master (
    output JumpOP, Stall, Imm, RsData, JTarget,
    input  PCout, PC_plus4, Flush, Misalign
  );

  modport slave (
    input  JumpOP, Stall, Imm, RsData, JTarget,
    output PCout, PC_plus4, Flush, Misalign
  );
endinterface

// File: rtl/pc_target_calc.sv
// pc_target_calc: purely combinational next-PC target selection.
//   pc_i        [31:0] current PC
//   imm_i       [15:0] branch offset in words
//   rs_data_i   [31:0] JR target
//   jtarget_i   [25:0] J-format target field
//   jump_op_i   [1:0]  select code
//   plus4_o     [31:0] pc_i + 4
//   target_o    [31:0] selected target (TRAP_PC substituted for unaligned JR)
//   misalign_o         selected op is JR with an unaligned target
module pc_target_calc
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_PC = 32'h0000_0080
) (
  input  logic [31:0] pc_i,
  input  logic [15:0] imm_i,
  input  logic [31:0] rs_data_i,
  input  logic [25:0] jtarget_i,
  input  logic [1:0]  jump_op_i,
  output logic [31:0] plus4_o,
  output logic [31:0] target_o,
  output logic        misalign_o
);

  logic [31:0] plus4;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic        rs_unaligned;

  // All arithmetic wraps modulo 2^32 by construction of the 32-bit adders.
  assign plus4        = pc_i + PC_STEP;
  assign br_target    = plus4 + branch_offset(imm_i);
  assign jmp_target   = {plus4[31:28], jtarget_i, 2'b00};
  assign rs_unaligned = (rs_data_i[1:0] != 2'b00);
  assign plus4_o      = plus4;

  always_comb begin
    target_o   = plus4;
    misalign_o = 1'b0;
    case (jump_op_e'(jump_op_i))
      PCOUT_PLUS4: target_o = plus4;
      BRANCH:      target_o = br_target;
      JR: begin
        target_o   = rs_unaligned ? TRAP_PC : rs_data_i;
        misalign_o = rs_unaligned;
      end
      JUMP:        target_o = jmp_target;
      default:     target_o = plus4;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter register and next-PC sequencer.
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : pc_ctrl_if.slave (JumpOP/Stall/Imm/RsData/JTarget in;
//          PCout/PC_plus4/Flush/Misalign out)
// A redirect requested while stalled is parked in a pending register
// (HOLD state) and committed when the stall clears; the first captured
// redirect wins and later requests during the stall are ignored.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
  input  logic clk,
  input  logic rst,
  pc_ctrl_if.slave bus
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_mis_q, pend_mis_d;

  logic [31:0] plus4;
  logic [31:0] sel_target;
  logic        sel_misalign;
  logic        redirect;

  pc_target_calc #(
    .TRAP_PC (TRAP_PC)
  ) u_target (
    .pc_i       (pc_q),
    .imm_i      (bus.Imm),
    .rs_data_i  (bus.RsData),
    .jtarget_i  (bus.JTarget),
    .jump_op_i  (bus.JumpOP),
    .plus4_o    (plus4),
    .target_o   (sel_target),
    .misalign_o (sel_misalign)
  );

  assign redirect = (bus.JumpOP != PCOUT_PLUS4);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      pend_target_q <= '0;
      pend_mis_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      pend_target_q <= pend_target_d;
      pend_mis_q    <= pend_mis_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_d       = 1'b0;
    misalign_d    = 1'b0;
    pend_target_d = pend_target_q;
    pend_mis_d    = pend_mis_q;

    case (state_q)
      RUN: begin
        if (!bus.Stall) begin
          pc_d       = sel_target;
          flush_d    = redirect;
          misalign_d = sel_misalign;
        end else if (redirect) begin
          // Park the redirect; TRAP_PC substitution is already applied.
          pend_target_d = sel_target;
          pend_mis_d    = sel_misalign;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (!bus.Stall) begin
          pc_d          = pend_target_q;
          flush_d       = 1'b1;
          misalign_d    = pend_mis_q;
          pend_target_d = '0;
          pend_mis_d    = 1'b0;
          state_d       = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.PCout    = pc_q;
  assign bus.PC_plus4 = plus4;
  assign bus.Flush    = flush_q;
  assign bus.Misalign = misalign_q;

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        flush;
    logic        mis;
  } exp_t;

  logic clk;
  logic rst;
  pc_ctrl_if bus ();

  exp_t exp_q[$];
  int   total;
  int   bad;

  pc_ctrl #(
    .RESET_PC (32'h0000_0000),
    .TRAP_PC  (32'h0000_0080)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Apply one cycle of stimulus and queue the response expected after the edge.
  task automatic drive(input string name, input logic r, input logic st,
                       input logic [1:0] jop, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [25:0] jt,
                       input logic [31:0] e_pc, input logic e_f, input logic e_m);
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.Stall   = st;
    bus.JumpOP  = jop;
    bus.Imm     = imm;
    bus.RsData  = rs;
    bus.JTarget = jt;
    e.name  = name;
    e.pc    = e_pc;
    e.flush = e_f;
    e.mis   = e_m;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge produces a new registered PC/Flush/Misalign.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("[%0t] %s pc=%h plus4=%h flush=%b mis=%b", $time, e.name,
                 bus.PCout, bus.PC_plus4, bus.Flush, bus.Misalign);
        check({e.name, ".pc"},    bus.PCout,           e.pc);
        check({e.name, ".plus4"}, bus.PC_plus4,        e.pc + 32'd4);
        check({e.name, ".flush"}, {31'd0, bus.Flush},  {31'd0, e.flush});
        check({e.name, ".mis"},   {31'd0, bus.Misalign}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    int wait_cycles;
    total = 0;
    bad   = 0;
    rst = 1'b0;
    bus.Stall = 1'b0; bus.JumpOP = 2'd0; bus.Imm = '0; bus.RsData = '0; bus.JTarget = '0;

    // 1: reset then sequential fetch
    drive("rst0",  0, 0, 2'd0, 16'h0, 32'h0, 26'h0, 32'h0000_0000, 0, 0);
    drive("rst1",  0, 0, 2'd0, 16'h0, 32'h0, 26'h0, 32'h0000_0000, 0, 0);
    drive("seq4",  1, 0, 2'd0, 16'h0, 32'h0, 26'h0, 32'h0000_0004, 0, 0);
    drive("seq8",  1, 0, 2'd0, 16'h0, 32'h0, 26'h0, 32'h0000_0008, 0, 0);
    drive("seqC",  1, 0, 2'd0, 16'h0, 32'h0, 26'h0, 32'h0000_000C, 0, 0);
    // 2: branches from 0x100
    drive("jr100a", 1, 0, 2'd2, 16'h0,    32'h100, 26'h0, 32'h0000_0100, 1, 0);
    drive("brneg",  1, 0, 2'd1, 16'hFFFC, 32'h0,   26'h0, 32'h0000_00F4, 1, 0);
    drive("jr100b", 1, 0, 2'd2, 16'h0,    32'h100, 26'h0, 32'h0000_0100, 1, 0);
    drive("brpos",  1, 0, 2'd1, 16'h0003, 32'h0,   26'h0, 32'h0000_0110, 1, 0);
    // 3: J keeps the upper nibble of PC+4
    drive("jr3k",   1, 0, 2'd2, 16'h0, 32'h3000_0010, 26'h0,      32'h3000_0010, 1, 0);
    drive("jump",   1, 0, 2'd3, 16'h0, 32'h0,         26'h000_0040, 32'h3000_0100, 1, 0);
    // 4: JR misaligned and aligned; flush drops after one cycle
    drive("jrmis",  1, 0, 2'd2, 16'h0, 32'h0000_0202, 26'h0, 32'h0000_0080, 1, 1);
    drive("jr400",  1, 0, 2'd2, 16'h0, 32'h0000_0400, 26'h0, 32'h0000_0400, 1, 0);
    drive("after",  1, 0, 2'd0, 16'h0, 32'h0,         26'h0, 32'h0000_0404, 0, 0);
    // 5: redirect captured during stall, first one wins
    drive("jr200",  1, 0, 2'd2, 16'h0,    32'h200,  26'h0,   32'h0000_0200, 1, 0);
    drive("stj",    1, 1, 2'd3, 16'h0,    32'h0,    26'h100, 32'h0000_0200, 0, 0);
    drive("stbr1",  1, 1, 2'd1, 16'h0003, 32'h0,    26'h0,   32'h0000_0200, 0, 0);
    drive("stbr2",  1, 1, 2'd1, 16'h0003, 32'h0,    26'h0,   32'h0000_0200, 0, 0);
    drive("commit", 1, 0, 2'd2, 16'h0,    32'h1000, 26'h0,   32'h0000_0400, 1, 0);
    drive("post",   1, 0, 2'd0, 16'h0,    32'h0,    26'h0,   32'h0000_0404, 0, 0);
    // pending misaligned JR carries its flag through HOLD
    drive("stjrm",  1, 1, 2'd2, 16'h0, 32'h0000_0003, 26'h0, 32'h0000_0404, 0, 0);
    drive("sthold", 1, 1, 2'd0, 16'h0, 32'h0,         26'h0, 32'h0000_0404, 0, 0);
    drive("cmtmis", 1, 0, 2'd0, 16'h0, 32'h0,         26'h0, 32'h0000_0080, 1, 1);
    drive("post2",  1, 0, 2'd0, 16'h0, 32'h0,         26'h0, 32'h0000_0084, 0, 0);
    // 6: reset while HOLD discards the pending redirect
    drive("jr200b", 1, 0, 2'd2, 16'h0, 32'h200, 26'h0,   32'h0000_0200, 1, 0);
    drive("stj2",   1, 1, 2'd3, 16'h0, 32'h0,   26'h100, 32'h0000_0200, 0, 0);
    drive("rsthld", 0, 1, 2'd1, 16'h0, 32'h0,   26'h0,   32'h0000_0000, 0, 0);
    drive("rel4",   1, 0, 2'd0, 16'h0, 32'h0,   26'h0,   32'h0000_0004, 0, 0);
    drive("rel8",   1, 0, 2'd0, 16'h0, 32'h0,   26'h0,   32'h0000_0008, 0, 0);
    // stall with no redirect holds; wrap-around of PC+4
    drive("sthold0", 1, 1, 2'd0, 16'h0, 32'h0,         26'h0, 32'h0000_0008, 0, 0);
    drive("jrtop",   1, 0, 2'd2, 16'h0, 32'hFFFF_FFFC, 26'h0, 32'hFFFF_FFFC, 1, 0);
    drive("wrap",    1, 0, 2'd0, 16'h0, 32'h0,         26'h0, 32'h0000_0000, 0, 0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    check("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Program-counter register and next-PC sequencer for the single-cycle/multi-cycle MIPS datapath. It consumes the 2-bit JumpOP produced by the jump control and computes four targets: PC+4, branch, JR and J. It commits the selected target on the next clock edge. It also buffers a redirect that arrives while the pipeline is stalled, and raises a one-cycle Flush whenever a redirect commits.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TRAP_PC, 32'h0000_0080, PC loaded when a JR target is not word-aligned.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-low.
JumpOP  input  2  next-PC select: 0 = PC+4, 1 = branch, 2 = JR, 3 = jump.
Stall  input  1  1 = hold PC this cycle (hazard/memory wait).
Imm  input  16  branch offset in words, sign-extended internally.
RsData  input  32  JR target address.
JTarget  input  26  J-format target field.
PCout  output  32  current PC (registered).
PC_plus4  output  32  PCout + 4, combinational, for link/branch use.
Flush  output  1  registered; high for exactly one cycle when a redirect (JumpOP != 0) commits.
Misalign  output  1  registered; high for one cycle when a committed JR target had RsData[1:0] != 0.

Behaviour:
- Reset, when rst = 0 at a clock edge:
  - PCout = RESET_PC; Flush = 0; Misalign = 0.
  - state = RUN; pending target cleared.
  - Reset overrides Stall and JumpOP, and discards any pending redirect.
- Target arithmetic, all computed from the current PCout, modulo 2^32 (wrap-around permitted, no flag):
  - plus4 = PCout + 4.
  - br = plus4 + {{14{Imm[15]}}, Imm, 2'b00}.
  - jr = RsData; if RsData[1:0] != 0, the target is TRAP_PC and the misaligned condition is set.
  - jmp = {plus4[31:28], JTarget, 2'b00}.
- States: RUN, HOLD.
- RUN, Stall = 0:
  - PCout <= target selected by JumpOP.
  - Flush <= (JumpOP != 0).
  - Misalign <= (JumpOP == 2 && RsData[1:0] != 0).
- RUN, Stall = 1, JumpOP = 0: PCout holds; Flush <= 0; Misalign <= 0.
- RUN, Stall = 1, JumpOP != 0:
  - Capture the selected target (after the misalign substitution) into the pending register.
  - Capture the misalign condition into a pending flag.
  - Go to HOLD; PCout holds; Flush <= 0.
- HOLD, Stall = 1: hold everything. JumpOP, Imm, RsData and JTarget are ignored; the first captured redirect wins.
- HOLD, Stall = 0:
  - PCout <= pending target; Flush <= 1; Misalign <= pending flag.
  - Clear the pending state; go to RUN.
  - JumpOP in this cycle is ignored.
- Latency: redirect visible on PCout one edge after the decision cycle with Stall = 0. Flush and Misalign are high in the same cycle the new PCout is visible.
- Flush and Misalign are never high for more than one consecutive cycle per redirect.

Decomposition:
- A shared header holds the JumpOP encodings (PCOUT_PLUS4 = 0, BRANCH = 1, JR = 2, JUMP = 3) and the RUN/HOLD state codes. The jump control and pc_ctrl both include this header, so the two ends cannot diverge.
- One natural combinational sub-module: pc_target_calc. It takes PCout, Imm, RsData, JTarget and JumpOP, and returns the selected target plus the misalign bit.
- The registers and the RUN/HOLD FSM stay in pc_ctrl.

Test Plan:
1. Reset with rst = 0 for 2 cycles, then rst = 1 and JumpOP = 0 for 3 cycles -> PCout 0x0, 0x4, 0x8, 0xC; Flush = 0 throughout.
2. At PCout = 0x100, JumpOP = 1, Imm = 16'hFFFC -> next PCout = 0x0F4, Flush = 1 for one cycle. Repeat with Imm = 16'h0003 -> PCout = 0x110.
3. At PCout = 0x3000_0010, JumpOP = 3, JTarget = 26'h000_0040 -> PCout = 0x3000_0100, Flush pulses.
4. JumpOP = 2, RsData = 0x0000_0202 -> PCout = TRAP_PC 0x80, Flush = 1, Misalign = 1 for one cycle. RsData = 0x400 -> PCout = 0x400, Misalign = 0.
5. At PCout = 0x200 with Stall = 1 for 3 cycles:
   - First stalled cycle: JumpOP = 3, JTarget = 0x100.
   - Later stalled cycles: JumpOP = 1.
   - Result: PCout holds 0x200; after Stall drops, PCout = 0x400 with a single Flush pulse.
6. Same stalled-redirect setup, with rst = 0 asserted while in HOLD -> PCout = RESET_PC, no Flush. After release, PC+4 sequencing resumes and the pending redirect is never applied.
